vpu_sram_rd_bank_arbiter: RTL
=============================

// Module: vpu_sram_rd_bank_arbiter
// PURPOSE
//  Per-bank read arbiter between the VPU SRAM read ports (src0/src1/src2) and one SRAM bank.
//  Grants one port at a time in round-robin order and locks the grant for a whole burst (until rlast).
//  Issues read beats to the bank and routes returned data back to the owning port after a fixed latency.
//  One instance per bank sits between the VPU_TOP read ports and the SRAM macros.
// PARAMETERS
//  PORT_CNT     3    number of requesting read ports (SRAM_READ_PORT_CNT)
//  BANK_ID      0    bank served; a port is eligible only when its rid equals BANK_ID
//  BANK_ID_W    SRAM_BANK_CNT_LG2    width of rid
//  ADDR_W       SRAM_BANK_DEPTH_LG2  bank word address width
//  DATA_W       SRAM_DATA_WIDTH      read data width
//  RD_LAT       2    SRAM read latency in cycles (>=1)
//  TIMEOUT_CYC  256  watchdog limit; used only with VPU_RD_ARB_TIMEOUT_EN
// PORTS
//  clk          in   1                  clock
//  rst_n        in   1                  asynchronous active-low reset
//  rreq_i       in   PORT_CNT           per-port request, held high for the whole burst
//  rid_i        in   PORT_CNT*BANK_ID_W per-port target bank
//  raddr_i      in   PORT_CNT*ADDR_W    per-port beat address
//  reb_i        in   PORT_CNT           per-port read strobe, active low
//  rlast_i      in   PORT_CNT           per-port last-beat marker
//  rack_o       out  PORT_CNT           beat accepted this cycle
//  rdata_o      out  PORT_CNT*DATA_W    returned data; all lanes carry the same word, qualified by rvalid_o
//  rvalid_o     out  PORT_CNT           returned data valid for that port
//  sram_cs_o    out  1                  bank read select
//  sram_addr_o  out  ADDR_W             bank read address
//  sram_rdata_i in   DATA_W             bank read data, valid RD_LAT cycles after sram_cs_o
//  err_o        out  1                  sticky watchdog error
// BEHAVIOUR
//  Reset values: state=IDLE, rr_ptr=0, grant=0, all return-pipe valids=0.
//   All outputs are 0: rack_o, rvalid_o, sram_cs_o, sram_addr_o, err_o, rdata_o.
//  Eligibility: elig[p] = rreq_i[p] & (rid_i[p]==BANK_ID).
//  FSM IDLE:
//   - If any elig: pick the first eligible port at or after rr_ptr (cyclic order).
//   - Register grant=p and go to BURST next cycle. Arbitration costs 1 cycle.
//   - No rack_o and no sram_cs_o in IDLE.
//  FSM BURST, combinational per cycle:
//   - beat = rreq_i[g] & ~reb_i[g].
//   - rack_o[g] = beat; sram_cs_o = beat; sram_addr_o = raddr_i[g] when beat, else holds the last value.
//   - Non-granted ports: rack_o = 0.
//  Burst end: a beat with rlast_i[g]=1 -> state=IDLE and rr_ptr = (g+1) mod PORT_CNT.
//   - Requests present in that same cycle are arbitrated in the following IDLE cycle (no back-to-back grant).
//  Granted port stalling:
//   - rreq_i[g]=1 with reb_i[g]=1 -> no beat; lock held.
//   - rreq_i[g]=0 -> lock held (no release without rlast).
//  Single-beat burst: rlast on the first beat is legal; 1 beat, then IDLE.
//  Return path:
//   - RD_LAT-deep shift pipe of {valid, port idx} loaded on every beat.
//   - rvalid_o[idx] = 1 exactly RD_LAT cycles after that port's rack_o. rdata_o lanes = sram_rdata_i.
//   - Return pipe drains independently of the FSM; data for a finished burst still returns after the FSM leaves BURST.
//  Throughput: 1 beat/cycle during BURST. Beats of one burst return in issue order.
//  rr_ptr wraps PORT_CNT-1 -> 0. Ports not eligible are skipped with no cycle penalty.
//  Reset asserted mid-burst: FSM to IDLE, pipe cleared, in-flight data dropped; no rvalid_o after reset.
// CONFIGURATION
//  VPU_RD_ARB_TIMEOUT_EN defined:
//   - In BURST, a counter increments on every cycle without a beat and clears on a beat.
//   - Reaching TIMEOUT_CYC: force IDLE, advance rr_ptr past g, set err_o=1 (sticky until reset).
//  VPU_RD_ARB_TIMEOUT_EN not defined:
//   - No counter; err_o tied 0; lock is held indefinitely until rlast.
// TESTING
//  1 Single port: p0 rid=BANK_ID, 4 beats addr 0x10..0x13, rlast on 4th.
//    -> rack_o[0] on 4 consecutive cycles starting 1 cycle after rreq.
//    -> rvalid_o[0] RD_LAT cycles after each beat, data = mem[0x10..0x13].
//  2 All 3 ports request 2-beat bursts together from reset.
//    -> grant order p0,p1,p2. 1 IDLE cycle between bursts. No rack_o on non-granted ports.
//  3 p1 finishes (rr_ptr=2), then p0 and p1 request together.
//    -> p0 is granted first (cyclic order from 2 skips the idle p2 and wraps to 0).
//  4 rid mismatch: p2 rid=BANK_ID+1 with rreq=1 -> never granted; rack_o=0, sram_cs_o=0.
//  5 Granted p0 holds reb=1 for 3 cycles mid-burst while p1 requests.
//    -> lock kept; p1 is not granted until p0's rlast beat.
//  6 Reset mid-burst with 2 beats in flight -> rvalid_o stays 0 afterwards.
//    With VPU_RD_ARB_TIMEOUT_EN and TIMEOUT_CYC=8: p0 stalls 8 cycles -> err_o=1, p1 granted.

Source files
------------

// File: rtl/vpu_sram_rd_bank_arbiter.sv
// Round-robin read arbiter for one VPU SRAM bank: locks a port for a whole burst and returns data after RD_LAT cycles.
// Optional watchdog enabled by defining VPU_RD_ARB_TIMEOUT_EN.
module vpu_sram_rd_bank_arbiter #(
    parameter int PORT_CNT    = 3,
    parameter int BANK_ID     = 0,
    parameter int BANK_ID_W   = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int RD_LAT      = 2,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PORT_CNT-1:0]           rreq_i,
    input  logic [PORT_CNT*BANK_ID_W-1:0] rid_i,
    input  logic [PORT_CNT*ADDR_W-1:0]    raddr_i,
    input  logic [PORT_CNT-1:0]           reb_i,
    input  logic [PORT_CNT-1:0]           rlast_i,
    output logic [PORT_CNT-1:0]           rack_o,
    output logic [PORT_CNT*DATA_W-1:0]    rdata_o,
    output logic [PORT_CNT-1:0]           rvalid_o,
    output logic                          sram_cs_o,
    output logic [ADDR_W-1:0]             sram_addr_o,
    input  logic [DATA_W-1:0]             sram_rdata_i,
    output logic                          err_o
);

    localparam int GW = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state;
    logic [GW-1:0]       grant;
    logic [GW-1:0]       rr_ptr;
    logic [GW-1:0]       pick;
    logic [GW-1:0]       next_ptr;
    logic                any_elig;
    logic [PORT_CNT-1:0] elig;
    logic                beat;
    logic                last_beat;
    logic                timeout;
    logic [ADDR_W-1:0]   g_addr;
    logic [ADDR_W-1:0]   addr_q;
    logic [RD_LAT-1:0]   pipe_vld;
    logic [GW-1:0]       pipe_idx [RD_LAT];

    always_comb begin
        for (int p = 0; p < PORT_CNT; p++) begin
            elig[p] = rreq_i[p] && (rid_i[p*BANK_ID_W +: BANK_ID_W] == BANK_ID_W'(BANK_ID));
        end
    end

    // Scan from the far end so the port closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        int k;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pick     = '0;
        any_elig = 1'b0;
        for (int i = PORT_CNT - 1; i >= 0; i--) begin
            k = int'(rr_ptr) + i;
            if (k >= PORT_CNT) k = k - PORT_CNT;
            if (elig[k]) begin
                pick     = GW'(k);
                any_elig = 1'b1;
            end
        end
    end

    assign beat      = (state == BURST) && rreq_i[grant] && !reb_i[grant];
    assign last_beat = beat && rlast_i[grant];
    assign g_addr    = raddr_i[grant*ADDR_W +: ADDR_W];
    assign next_ptr  = (grant == GW'(PORT_CNT - 1)) ? '0 : grant + 1'b1;

    assign rack_o      = beat ? (PORT_CNT'(1) << grant) : '0;
    assign sram_cs_o   = beat;
    assign sram_addr_o = beat ? g_addr : addr_q;
    assign rvalid_o    = pipe_vld[RD_LAT-1] ? (PORT_CNT'(1) << pipe_idx[RD_LAT-1]) : '0;
    assign rdata_o     = pipe_vld[RD_LAT-1] ? {PORT_CNT{sram_rdata_i}} : '0;

`ifdef VPU_RD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] stall_cnt;
    logic          err_q;

    assign timeout = (state == BURST) && !beat && (stall_cnt == CW'(TIMEOUT_CYC - 1));
    assign err_o   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state != BURST || beat || timeout) stall_cnt <= '0;
            else                                   stall_cnt <= stall_cnt + 1'b1;
            if (timeout) err_q <= 1'b1;
        end
    end
`else
    // Watchdog absent: the lock is released only by rlast and err_o is constant 0.
    assign timeout = 1'b0;
    assign err_o   = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            addr_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        grant <= pick;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (beat) addr_q <= g_addr;
                    if (last_beat || timeout) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= beat;
            for (int i = 1; i < RD_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
    end

    // NOTE: the index payload has no reset; it is only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        pipe_idx[0] <= grant;
        for (int i = 1; i < RD_LAT; i++) pipe_idx[i] <= pipe_idx[i-1];
    end

endmodule
